// File: rtl/temporizador_contagem.sv
// MM:SS countdown timer: shifts in BCD keypad digits, counts down once per 1 Hz tick.
// Optional buzzer pulse after expiry is enabled by defining TIMER_ALARM_EN.
module temporizador_contagem #(
    parameter int SYNC_STAGES   = 2,
    parameter int SEC_WRAP_TENS = 5,
    parameter int ALARM_TICKS   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] D,
    input  logic       loadn,
    input  logic       pgt_1Hz,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done,
    output logic       zero,
    output logic       alarm,
    output logic [1:0] state_dbg
);

    // start/stop are single-cycle request pulses sampled on every rising edge with no
    // acknowledge; stop outranks start whenever both are high in the same cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_t;

    if (SYNC_STAGES < 2 || ALARM_TICKS < 1) begin : g_param_check
        $error("temporizador_contagem: SYNC_STAGES must be >= 2 and ALARM_TICKS >= 1");
    end

    state_t                 state, state_n;
    logic [15:0]            digits, digits_n, shifted, decremented;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q, loadn_q, tick, key_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            sync_q  <= 1'b0;
            loadn_q <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pgt_1Hz};
            sync_q  <= sync_ff[SYNC_STAGES-1];
            loadn_q <= loadn;
        end
    end

    assign tick    = sync_ff[SYNC_STAGES-1] & ~sync_q;
    assign key_evt = loadn & ~loadn_q;

    // Seconds may hold up to 99 from entry, so borrow only looks at "is this digit zero".
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] != 4'd0) begin
            r[3:0] = v[3:0] - 4'd1;
        end else if (v[7:4] != 4'd0) begin
            r[7:4] = v[7:4] - 4'd1;
            r[3:0] = 4'd9;
        end else if (v[15:8] != 8'd0) begin
            r[7:0] = {4'(SEC_WRAP_TENS), 4'd9};
            if (v[11:8] != 4'd0) begin
                r[11:8] = v[11:8] - 4'd1;
            end else begin
                r[11:8]  = 4'd9;
                r[15:12] = v[15:12] - 4'd1;
            end
        end
        return r;
    endfunction

    always_comb begin
        state_n     = state;
        digits_n    = digits;
        shifted     = (key_evt && D <= 4'd9) ? {digits[11:0], D} : digits;
        decremented = bcd_dec(digits);
        case (state)
            IDLE: begin
                if (stop) begin
                    digits_n = '0;
                end else begin
                    digits_n = shifted;
                    if (start && shifted != 16'd0) state_n = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = PAUSE;
                end else if (tick) begin
                    digits_n = decremented;
                    if (decremented == 16'd0) state_n = DONE;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_n  = IDLE;
                    digits_n = '0;
                end else if (start) begin
                    state_n = RUN;
                end
            end
            DONE: begin
                digits_n = '0;
                if (start || stop || key_evt) state_n = IDLE;
            end
            default: begin
                state_n  = IDLE;
                digits_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            digits  <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            digits  <= digits_n;
            running <= (state_n == RUN);
            done    <= (state_n == DONE);
        end
    end

`ifdef TIMER_ALARM_EN
    localparam int AW = $clog2(ALARM_TICKS + 1);
    logic [AW-1:0] alarm_cnt;

    // The tick that causes expiry is not counted; the alarm lasts ALARM_TICKS further ticks.
    always_ff @(posedge clk) begin
        if (rst || state_n != DONE) begin
            alarm     <= 1'b0;
            alarm_cnt <= '0;
        end else if (state != DONE) begin
            alarm     <= 1'b1;
            alarm_cnt <= '0;
        end else if (alarm && tick) begin
            alarm_cnt <= alarm_cnt + 1'b1;
            if (alarm_cnt == AW'(ALARM_TICKS - 1)) alarm <= 1'b0;
        end
    end
`else
    assign alarm = 1'b0;
`endif

    assign {min_tens, min_ones, sec_tens, sec_ones} = digits;
    assign zero      = (digits == 16'd0);
    assign state_dbg = state;

endmodule
